// File: rtl/if_pkg.sv
// Shared types for the instruction prefetch path: halfword buffer entry and RVC length decode.
package if_pkg;

    localparam logic [1:0] RVC_LONG_OPC = 2'b11;

    typedef struct packed {
        logic [15:0] data;
        logic [30:0] pc;
    } hw_entry_t;

    function automatic logic is_long(input logic [15:0] hw);
        return hw[1:0] == RVC_LONG_OPC;
    endfunction

endpackage

// File: rtl/u_hw_fifo.sv
// Circular halfword FIFO: up to two pushes and two pops per cycle, plus flush.
module u_hw_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush,
    input  logic [1:0]               push_n,
    input  hw_entry_t                push_d0,
    input  hw_entry_t                push_d1,
    input  logic [1:0]               pop_n,
    output hw_entry_t                head,
    output logic [15:0]              head_next_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    hw_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_n);
            wr_ptr <= wr_ptr + PTR_W'(push_n);
            count  <= count + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_n != 2'd0) mem[wr_ptr] <= push_d0;
        if (push_n == 2'd2) mem[wr_ptr + PTR_W'(1)] <= push_d1;
    end

    assign head           = mem[rd_ptr];
    assign head_next_data = mem[rd_ptr + PTR_W'(1)].data;

endmodule

// File: rtl/u_if_prefetch.sv
// Instruction prefetch: word fetch into a halfword buffer, RVC realignment, branch redirect.
module u_if_prefetch
    import if_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 8,
    parameter logic [30:0] RESET_PC  = 31'h0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          cache_req_o,
    output logic [29:0]                   cache_address_o,
    input  logic [31:0]                   cache_data_i,
    input  logic                          cache_blocking_n_i,
    input  logic                          branching,
    input  logic [30:0]                   branch_pc,
    input  logic                          stall,
    output logic [31:0]                   instr_o,
    output logic                          is_long_o,
    output logic [30:0]                   pc_o,
    output logic                          instr_valid_o,
    output logic                          ins_busywait_o,
    output logic [$clog2(BUF_DEPTH):0]    buf_count_o
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [29:0]      fetch_counter;
    logic             skip_low;
    logic [30:0]      head_pc;
    hw_entry_t        head;
    hw_entry_t        push_d0;
    hw_entry_t        push_d1;
    logic [15:0]      head_next_data;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             head_long;

    u_hw_fifo #(
        .DEPTH(BUF_DEPTH)
    ) u_fifo (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush          (branching),
        .push_n         (push_n),
        .push_d0        (push_d0),
        .push_d1        (push_d1),
        .pop_n          (pop_n),
        .head           (head),
        .head_next_data (head_next_data),
        .count          (count)
    );

    // Request only with room for a full word; a redirect suppresses push and pop.
    always_comb begin
        cache_req_o  = !rst_i && !branching && (count <= CNT_W'(BUF_DEPTH - 2));
        accept       = cache_req_o && cache_blocking_n_i;

        push_d0.data = skip_low ? cache_data_i[31:16] : cache_data_i[15:0];
        push_d0.pc   = {fetch_counter, skip_low};
        push_d1.data = cache_data_i[31:16];
        push_d1.pc   = {fetch_counter, 1'b1};
        push_n       = accept ? (skip_low ? 2'd1 : 2'd2) : 2'd0;

        head_long     = is_long(head.data);
        instr_valid_o = !branching &&
                        (head_long ? (count >= CNT_W'(2)) : (count >= CNT_W'(1)));
        pop_n         = (instr_valid_o && !stall) ? (head_long ? 2'd2 : 2'd1) : 2'd0;

        instr_o = 32'h0;
        if (instr_valid_o) instr_o = head_long ? {head_next_data, head.data} : {16'h0, head.data};
        is_long_o      = instr_valid_o && head_long;
        pc_o           = (count != '0) ? head.pc : head_pc;
        ins_busywait_o = !instr_valid_o;
    end

    assign cache_address_o = fetch_counter;
    assign buf_count_o     = count;

    // head_pc tracks the next expected pc so pc_o is meaningful while the buffer is empty.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_counter <= RESET_PC[30:1];
            skip_low      <= RESET_PC[0];
            head_pc       <= RESET_PC;
        end else if (branching) begin
            fetch_counter <= branch_pc[30:1];
            skip_low      <= branch_pc[0];
            head_pc       <= branch_pc;
        end else begin
            if (accept) begin
                fetch_counter <= fetch_counter + 30'd1;
                skip_low      <= 1'b0;
            end
            head_pc <= head_pc + 31'(pop_n);
        end
    end

endmodule

// File: tb/tb_u_if_prefetch.sv
// Directed bench for u_if_prefetch with a zero-wait cache model backed by a word array.
module tb_u_if_prefetch;

    localparam int unsigned BUF_DEPTH = 8;
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH) + 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             cache_req_o;
    logic [29:0]      cache_address_o;
    logic [31:0]      cache_data_i;
    logic             cache_blocking_n_i;
    logic             branching;
    logic [30:0]      branch_pc;
    logic             stall;
    logic [31:0]      instr_o;
    logic             is_long_o;
    logic [30:0]      pc_o;
    logic             instr_valid_o;
    logic             ins_busywait_o;
    logic [CNT_W-1:0] buf_count_o;

    logic [31:0] mem [256];
    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    assign cache_data_i = mem[cache_address_o[7:0]];

    u_if_prefetch #(
        .BUF_DEPTH (BUF_DEPTH),
        .RESET_PC  (31'h0)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .cache_req_o        (cache_req_o),
        .cache_address_o    (cache_address_o),
        .cache_data_i       (cache_data_i),
        .cache_blocking_n_i (cache_blocking_n_i),
        .branching          (branching),
        .branch_pc          (branch_pc),
        .stall              (stall),
        .instr_o            (instr_o),
        .is_long_o          (is_long_o),
        .pc_o               (pc_o),
        .instr_valid_o      (instr_valid_o),
        .ins_busywait_o     (ins_busywait_o),
        .buf_count_o        (buf_count_o)
    );

    // Background stream: halfword k holds k*4, always a short encoding.
    function automatic logic [15:0] hw_pat(input int k);
        return 16'(k * 4);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 256; i++) mem[i] = {hw_pat(2 * i + 1), hw_pat(2 * i)};
    endtask

    task automatic pulse_reset(input string tag);
        cyc();
        rst_i = 1'b1;
        #1;
        check({tag, "_rst_valid"}, 64'(instr_valid_o), 64'd0);
        check({tag, "_rst_addr"}, 64'(cache_address_o), 64'd0);
        check({tag, "_rst_req"}, 64'(cache_req_o), 64'd0);
    endtask

    task automatic release_reset();
        cyc();
        rst_i = 1'b0;
        #2;
    endtask

    task automatic check_short(input string tag, input int k);
        check({tag, "_valid"}, 64'(instr_valid_o), 64'd1);
        check({tag, "_instr"}, 64'(instr_o), 64'({16'h0, hw_pat(k)}));
        check({tag, "_pc"}, 64'(pc_o), 64'(k));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          k;
        logic [29:0] a0;
        int          b0;
        int          exp_cnt [8] = '{0, 2, 4, 6, 8, 8, 8, 8};
        int          exp_req [8] = '{1, 1, 1, 1, 0, 0, 0, 0};

        rst_i = 1'b1; branching = 1'b0; branch_pc = 31'h0; stall = 1'b0; cache_blocking_n_i = 1'b1;
        load_pattern();
        mem[0] = 32'h00130093;
        #2;
        check("rst_valid", 64'(instr_valid_o), 64'd0);
        check("rst_req", 64'(cache_req_o), 64'd0);
        check("rst_instr", 64'(instr_o), 64'd0);
        check("rst_long", 64'(is_long_o), 64'd0);
        check("rst_pc", 64'(pc_o), 64'd0);
        check("rst_cnt", 64'(buf_count_o), 64'd0);
        check("rst_busy", 64'(ins_busywait_o), 64'd1);
        cyc();

        // Test 1: first fetch, long instruction next cycle
        release_reset();
        check("t1_req", 64'(cache_req_o), 64'd1);
        check("t1_addr", 64'(cache_address_o), 64'd0);
        check("t1_valid0", 64'(instr_valid_o), 64'd0);
        cyc(); #2;
        check("t1_valid", 64'(instr_valid_o), 64'd1);
        check("t1_long", 64'(is_long_o), 64'd1);
        check("t1_instr", 64'(instr_o), 64'h00130093);
        check("t1_pc", 64'(pc_o), 64'd0);
        check("t1_cnt", 64'(buf_count_o), 64'd2);
        check("t1_busy", 64'(ins_busywait_o), 64'd0);

        // Test 2: two shorts in one word
        pulse_reset("t2");
        load_pattern();
        mem[0] = 32'h45014501;
        release_reset();
        cyc(); #2;
        check("t2_instr0", 64'(instr_o), 64'h00004501);
        check("t2_long0", 64'(is_long_o), 64'd0);
        check("t2_pc0", 64'(pc_o), 64'd0);
        cyc(); #2;
        check("t2_instr1", 64'(instr_o), 64'h00004501);
        check("t2_pc1", 64'(pc_o), 64'd1);

        // Test 3: long instruction straddling a word boundary; word1 held off one cycle
        pulse_reset("t3");
        load_pattern();
        mem[0] = 32'h00934501;
        mem[1] = 32'h45010013;
        release_reset();
        cyc();
        cache_blocking_n_i = 1'b0;
        #2;
        check("t3_instr0", 64'(instr_o), 64'h00004501);
        check("t3_pc0", 64'(pc_o), 64'd0);
        cyc();
        cache_blocking_n_i = 1'b1;
        #2;
        check("t3_wait_valid", 64'(instr_valid_o), 64'd0);
        check("t3_wait_cnt", 64'(buf_count_o), 64'd1);
        cyc(); #2;
        check("t3_valid1", 64'(instr_valid_o), 64'd1);
        check("t3_instr1", 64'(instr_o), 64'h00130093);
        check("t3_long1", 64'(is_long_o), 64'd1);
        check("t3_pc1", 64'(pc_o), 64'd1);
        cyc(); #2;
        check("t3_instr2", 64'(instr_o), 64'h00004501);
        check("t3_pc2", 64'(pc_o), 64'd3);

        // Test 4: redirect to byte 0x106 with five halfwords buffered
        pulse_reset("t4");
        load_pattern();
        release_reset();
        cyc(); #2;
        cyc();
        stall = 1'b1;
        #2;
        cyc(); #2;
        check("t4_cnt5", 64'(buf_count_o), 64'd5);
        branching = 1'b1;
        branch_pc = 31'h83;
        #1;
        check("t4_br_valid", 64'(instr_valid_o), 64'd0);
        check("t4_br_req", 64'(cache_req_o), 64'd0);
        cyc();
        branching = 1'b0;
        stall     = 1'b0;
        #2;
        check("t4_flush_cnt", 64'(buf_count_o), 64'd0);
        check("t4_addr", 64'(cache_address_o), 64'h41);
        check("t4_req", 64'(cache_req_o), 64'd1);
        check("t4_empty_valid", 64'(instr_valid_o), 64'd0);
        cyc(); #2;
        check("t4_cnt1", 64'(buf_count_o), 64'd1);
        check_short("t4_first", 32'h83);

        // Test 5: stall fills the buffer, then release drains in order at one per cycle
        pulse_reset("t5");
        load_pattern();
        stall = 1'b1;
        release_reset();
        for (int i = 0; i < 8; i++) begin
            check("t5_cnt", 64'(buf_count_o), 64'(exp_cnt[i]));
            check("t5_req", 64'(cache_req_o), 64'(exp_req[i]));
            cyc(); #2;
        end
        check("t5_full_cnt", 64'(buf_count_o), 64'd8);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            stall = 1'b0;
            #1;
            check_short("t5_drain", k);
            k++;
            cyc(); #2;
        end

        // Test 6: three blocked cycles mid-stream, then resume, then async reset
        for (int i = 0; i < 3; i++) begin
            cache_blocking_n_i = 1'b0;
            #1;
            if (i == 0) begin
                a0 = cache_address_o;
                b0 = int'(buf_count_o);
            end else begin
                check("t6_addr_hold", 64'(cache_address_o), 64'(a0));
                check("t6_cnt_pop", 64'(buf_count_o), 64'(b0 - i));
            end
            check_short("t6_blk", k);
            k++;
            cyc(); #2;
        end
        for (int i = 0; i < 6; i++) begin
            cache_blocking_n_i = 1'b1;
            #1;
            check_short("t6_resume", k);
            k++;
            cyc(); #2;
        end
        rst_i = 1'b1;
        #1;
        check("t6_rst_valid", 64'(instr_valid_o), 64'd0);
        check("t6_rst_addr", 64'(cache_address_o), 64'd0);
        check("t6_rst_req", 64'(cache_req_o), 64'd0);
        check("t6_rst_cnt", 64'(buf_count_o), 64'd0);
        check("t6_rst_pc", 64'(pc_o), 64'd0);
        cyc();
        rst_i = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
